halve_tokens: RTL and testbench
===============================

# halve_tokens

Serial token decoder, the receive-side counterpart of `double_tokens`. It consumes the doubled serial stream `b`, collapses each pair of consecutive `1` tokens back into one original token, and buffers the recovered tokens as a pending count. The count drains through a valid/ready output handshake. Malformed input (a run of `1`s of odd length) and buffer exhaustion raise sticky error flags.

## Interface
- `MAX_PENDING`, default 200: maximum number of recovered tokens held while waiting for the consumer.
- `CNT_W`, default `$clog2(MAX_PENDING+1)`: width of the pending counter.
- `clk  input  1`: the single clock; all state updates on the rising edge.
- `rst_n  input  1`: asynchronous, active-low reset.
- `b  input  1`: doubled serial token stream, one bit per cycle, no backpressure.
- `tok_valid  output  1`: at least one recovered token is pending.
- `tok_ready  input  1`: consumer accepts one token when high together with `tok_valid`.
- `pending  output  CNT_W`: current recovered-token count.
- `overflow  output  1`: sticky; a token was dropped because the buffer was full.
- `parity_err  output  1`: sticky; an input run of `1`s ended with odd length.

## Operation
- Pair FSM, two states:
  - EVEN (reset state): `b=1` -> ODD; `b=0` -> stay in EVEN.
  - ODD: `b=1` -> EVEN and generate a push (pair complete); `b=0` -> EVEN, set `parity_err`, no push.
- Pop occurs when `tok_valid && tok_ready`.
- Counter update:
  - Push and no pop: `pending+1`.
  - Pop and no push: `pending-1`.
  - Push and pop together: unchanged.
  - Neither: unchanged.
- Push with `pending==MAX_PENDING` and no pop: token dropped, `pending` stays at `MAX_PENDING`, `overflow` set. Push and pop together at full is legal; no overflow.
- `tok_valid = (pending != 0)`, decoded from the registered count.
- No pop ever occurs when `pending==0`; `tok_ready` is ignored in that case.
- Errors do not stall the block. Decoding, counting and draining continue after `overflow` or `parity_err` is set.
- `overflow` and `parity_err` clear only through `rst_n` low.
- All arithmetic is unsigned in `CNT_W` bits. The counter never wraps: it saturates at `MAX_PENDING` by the drop rule and never goes below 0 by the pop guard.

## Timing
- Reset values: FSM = EVEN, `pending=0`, `tok_valid=0`, `overflow=0`, `parity_err=0`.
- Reset asserts asynchronously and takes effect immediately, including mid-operation. A half-received pair and all pending tokens are discarded.
- Latency: the second `1` of a pair is sampled at edge N; `pending` increments and `tok_valid` rises after edge N.
- A pop is sampled at edge N; the decremented `pending` is visible after edge N. Back-to-back pops drain one token per cycle.
- `parity_err` and `overflow` are registered. Each rises after the edge that samples the offending condition.
- `tok_valid` depends only on registered state. There is no combinational path from `tok_ready` or `b` to any output.

## Structure
- Package `halve_tokens_pkg`:
  - `MAX_PENDING_DEFAULT = 200`.
  - Enum `pair_state_t {EVEN, ODD}`.
- Sub-module `token_credit_counter`:
  - Parameters `MAX` and `W`.
  - Inputs `push`, `pop`.
  - Outputs `count`, `nonzero`, `drop`.
  - Contains the saturating up/down counter and the drop detection.
- Top level holds the pair FSM and the two sticky error flags, and instantiates `token_credit_counter`.

## Test plan
- Decode: `tok_ready=1`, drive `b` = 11011011110111111001111110. Required: 10 tokens popped in total, final `pending=0`, `parity_err=0`, `overflow=0`.
- Buffer: drive the same sequence with `tok_ready=0`. Required: `pending` ends at 10 and `tok_valid=1`. Then hold `tok_ready=1` for 10 cycles: `pending` steps 10 -> 0, one per cycle.
- Overflow: `tok_ready=0`, drive 402 consecutive `1`s. Required: `pending=200` after the 400th bit, `overflow` rises after the 402nd bit's edge, and `pending` stays at 200. Then set `tok_ready=1`: `pending` drains to 0 and `overflow` remains 1.
- Full with simultaneous push and pop: `pending=200`, `tok_ready=1`, drive a `1` pair. Required: `pending` stays at 200 and `overflow=0`.
- Parity: drive 1110. Required: one token pushed, `parity_err` rises after the edge sampling the 0, and the FSM returns to EVEN. A following 11 pushes one token normally.
- Reset mid-run: with `pending=5`, FSM in ODD and `overflow=1`, pulse `rst_n` low between clock edges. Required: all outputs read 0 immediately, and the next 11 input yields `pending=1`.

Source files
------------

// File: rtl/halve_tokens_pkg.sv
// Shared types and defaults for the doubled-token receive path.
package halve_tokens_pkg;

  localparam int unsigned MAX_PENDING_DEFAULT = 200;

  typedef enum logic {
    EVEN = 1'b0,
    ODD  = 1'b1
  } pair_state_t;

endpackage

// File: rtl/token_credit_counter.sv
// Saturating up/down count of recovered tokens; flags a push that finds the buffer full.
module token_credit_counter #(
  parameter int unsigned MAX = 200,
  parameter int unsigned W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  output logic [W-1:0] count,
  output logic         nonzero,
  output logic         drop
);

  logic         pop_ok;
  logic         full;
  logic [W-1:0] count_q;

  assign nonzero = (count_q != '0);
  assign full    = (count_q == W'(MAX));
  // A pop against an empty buffer is ignored, so the count never underflows.
  assign pop_ok  = pop && nonzero;
  assign drop    = push && !pop_ok && full;
  assign count   = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (push && !pop_ok) begin
      if (!full) count_q <= count_q + W'(1);
    end else if (pop_ok && !push) begin
      count_q <= count_q - W'(1);
    end
  end

endmodule

// File: rtl/halve_tokens.sv
// Collapses pairs of 1s in the doubled stream into single tokens and buffers them for a valid/ready consumer.
module halve_tokens
  import halve_tokens_pkg::*;
#(
  parameter int unsigned MAX_PENDING = MAX_PENDING_DEFAULT,
  parameter int unsigned CNT_W       = $clog2(MAX_PENDING + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             b,
  output logic             tok_valid,
  input  logic             tok_ready,
  output logic [CNT_W-1:0] pending,
  output logic             overflow,
  output logic             parity_err
);

  pair_state_t state_q, state_d;
  logic        push;
  logic        odd_end;
  logic        pop;
  logic        drop;
  logic        nonzero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EVEN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EVEN:    if (b) state_d = ODD;
      ODD:     state_d = EVEN;
      default: state_d = EVEN;
    endcase
  end

  always_comb begin
    push    = 1'b0;
    odd_end = 1'b0;
    if (state_q == ODD) begin
      push    = b;
      odd_end = !b;
    end
  end

  assign tok_valid = nonzero;
  assign pop       = tok_valid && tok_ready;

  token_credit_counter #(
    .MAX (MAX_PENDING),
    .W   (CNT_W)
  ) u_credit (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .count   (pending),
    .nonzero (nonzero),
    .drop    (drop)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow   <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (drop)    overflow   <= 1'b1;
      if (odd_end) parity_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_halve_tokens.sv
// Self-checking bench: vector table, directed corner sequences, and random traffic against a run-length model.
module tb_halve_tokens;

  localparam int unsigned MAXP  = 200;
  localparam int unsigned CNT_W = $clog2(MAXP + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             b;
  logic             tok_valid;
  logic             tok_ready;
  logic [CNT_W-1:0] pending;
  logic             overflow;
  logic             parity_err;

  int n_cmp = 0;
  int n_bad = 0;

  halve_tokens #(.MAX_PENDING(MAXP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .b          (b),
    .tok_valid  (tok_valid),
    .tok_ready  (tok_ready),
    .pending    (pending),
    .overflow   (overflow),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic b;
    logic rdy;
    int   pend;
    logic vld;
    logic ovf;
    logic perr;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic bi, input logic ri);
    b         = bi;
    tok_ready = ri;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    b         = 1'b0;
    tok_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Reference state: length of the current run of 1s and the token count.
  int   m_run, m_cnt;
  logic m_ovf, m_perr;

  task automatic model_step(input logic bi, input logic ri);
    logic push, pop;
    pop  = ri && (m_cnt > 0);
    push = 1'b0;
    if (bi) begin
      m_run++;
      push = (m_run % 2 == 0);
    end else begin
      if (m_run % 2 == 1) m_perr = 1'b1;
      m_run = 0;
    end
    if (push && !pop) begin
      if (m_cnt == MAXP) m_ovf = 1'b1;
      else               m_cnt++;
    end else if (pop && !push) begin
      m_cnt--;
    end
  endtask

  vec_t vt[$];
  logic [25:0] seq;
  int pops;

  initial begin
    rst_n     = 1'b1;
    b         = 1'b0;
    tok_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_pending", int'(pending), 0);
    chk("reset_valid", int'(tok_valid), 0);
    chk("reset_ovf", int'(overflow), 0);
    chk("reset_perr", int'(parity_err), 0);
    do_reset();

    // Parity handling and draining, expectations worked by hand.
    vt.push_back('{1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0});
    vt.push_back('{1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0});
    vt.push_back('{1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0});
    vt.push_back('{1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b1});
    vt.push_back('{1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b1});
    vt.push_back('{1'b1, 1'b0, 2, 1'b1, 1'b0, 1'b1});
    vt.push_back('{1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b1});
    vt.push_back('{1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b1});
    vt.push_back('{1'b1, 1'b1, 1, 1'b1, 1'b0, 1'b1});
    vt.push_back('{1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b1});
    vt.push_back('{1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b1});
    foreach (vt[i]) begin
      step(vt[i].b, vt[i].rdy);
      chk($sformatf("vec%0d_pending", i), int'(pending), vt[i].pend);
      chk($sformatf("vec%0d_valid", i), int'(tok_valid), int'(vt[i].vld));
      chk($sformatf("vec%0d_ovf", i), int'(overflow), int'(vt[i].ovf));
      chk($sformatf("vec%0d_perr", i), int'(parity_err), int'(vt[i].perr));
    end

    // Decode with a consumer that is always ready.
    do_reset();
    seq  = 26'b11011011110111111001111110;
    pops = 0;
    for (int i = 25; i >= 0; i--) begin
      if (tok_valid) pops++;
      step(seq[i], 1'b1);
    end
    for (int i = 0; i < 4; i++) begin
      if (tok_valid) pops++;
      step(1'b0, 1'b1);
    end
    chk("decode_pops", pops, 10);
    chk("decode_pending", int'(pending), 0);
    chk("decode_perr", int'(parity_err), 0);
    chk("decode_ovf", int'(overflow), 0);

    // Same stream buffered, then drained one per cycle.
    do_reset();
    for (int i = 25; i >= 0; i--) step(seq[i], 1'b0);
    chk("buffer_pending", int'(pending), 10);
    chk("buffer_valid", int'(tok_valid), 1);
    for (int i = 9; i >= 0; i--) begin
      step(1'b0, 1'b1);
      chk("buffer_drain", int'(pending), i);
    end

    // Overflow.
    do_reset();
    for (int i = 0; i < 400; i++) step(1'b1, 1'b0);
    chk("ovf_full_pending", int'(pending), 200);
    chk("ovf_not_yet", int'(overflow), 0);
    step(1'b1, 1'b0);
    chk("ovf_401_flag", int'(overflow), 0);
    step(1'b1, 1'b0);
    chk("ovf_402_flag", int'(overflow), 1);
    chk("ovf_402_pending", int'(pending), 200);
    for (int i = 199; i >= 0; i--) begin
      step(1'b0, 1'b1);
      if (i % 50 == 0) chk("ovf_drain", int'(pending), i);
    end
    chk("ovf_sticky", int'(overflow), 1);

    // Reset mid-run: 5 pending, half a pair received, overflow set.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("mid_pending_pre", int'(pending), 5);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_pending", int'(pending), 0);
    chk("mid_rst_valid", int'(tok_valid), 0);
    chk("mid_rst_ovf", int'(overflow), 0);
    chk("mid_rst_perr", int'(parity_err), 0);
    rst_n = 1'b1;
    step(1'b1, 1'b0);
    chk("mid_after_first", int'(pending), 0);
    step(1'b1, 1'b0);
    chk("mid_after_pair", int'(pending), 1);

    // Push and pop together while full.
    do_reset();
    for (int i = 0; i < 400; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk("full_pushpop_pending", int'(pending), 200);
    chk("full_pushpop_ovf", int'(overflow), 0);

    // Random traffic against the run-length model, with phases that fill and drain.
    do_reset();
    m_run = 0; m_cnt = 0; m_ovf = 1'b0; m_perr = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      logic rb, rr;
      if ((i / 1000) % 2 == 0) begin
        rb = ($urandom_range(99) < 85);
        rr = ($urandom_range(99) < 15);
      end else begin
        rb = ($urandom_range(99) < 50);
        rr = ($urandom_range(99) < 80);
      end
      model_step(rb, rr);
      step(rb, rr);
      if (int'(pending) != m_cnt || tok_valid != (m_cnt > 0) ||
          overflow != m_ovf || parity_err != m_perr) begin
        chk($sformatf("rand%0d_pending", i), int'(pending), m_cnt);
        chk($sformatf("rand%0d_valid", i), int'(tok_valid), int'(m_cnt > 0));
        chk($sformatf("rand%0d_ovf", i), int'(overflow), int'(m_ovf));
        chk($sformatf("rand%0d_perr", i), int'(parity_err), int'(m_perr));
      end else begin
        n_cmp++;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
